// File: rtl/cory_demux3.sv
// cory_demux3: one input stream steered by a select stream into three
// outputs, each buffered by its own 2-entry FIFO with registered readiness.
module cory_demux3 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    output logic         o_a_r,
    input  logic         i_s_v,
    input  logic [1:0]   i_s_d,
    output logic         o_s_r,
    output logic         o_z0_v,
    output logic [N-1:0] o_z0_d,
    input  logic         i_z0_r,
    output logic         o_z1_v,
    output logic [N-1:0] o_z1_d,
    input  logic         i_z1_r,
    output logic         o_z2_v,
    output logic [N-1:0] o_z2_d,
    input  logic         i_z2_r
);

    logic               w_go;
    logic               w_sel_full;
    logic [2:0]         w_full;
    logic [2:0]         w_v;
    logic [2:0]         w_rdy;
    logic [2:0][N-1:0]  w_d;

    assign w_go  = i_a_v & i_s_v;
    assign w_rdy = {i_z2_r, i_z1_r, i_z0_r};

    // Fullness of the addressed FIFO; the illegal select never blocks,
    // so that pair is drained and dropped.
    always_comb begin
        w_sel_full = 1'b0;
        case (i_s_d)
            2'd0:    w_sel_full = w_full[0];
            2'd1:    w_sel_full = w_full[1];
            2'd2:    w_sel_full = w_full[2];
            default: w_sel_full = 1'b0;
        endcase
    end

    // Readies only look at registered occupancy, never at downstream ready.
    assign o_a_r = i_s_v & ~w_sel_full;
    assign o_s_r = i_a_v & ~w_sel_full;

    for (genvar k = 0; k < 3; k++) begin : g_fifo
        logic [N-1:0] r_m0;
        logic [N-1:0] r_m1;
        logic         r_wp;
        logic         r_rp;
        logic [1:0]   r_cnt;
        logic         w_push;
        logic         w_pop;

        assign w_push   = w_go & (i_s_d == 2'(k)) & ~w_full[k];
        assign w_pop    = w_v[k] & w_rdy[k];
        assign w_full[k] = (r_cnt == 2'd2);
        assign w_v[k]    = (r_cnt != 2'd0);
        assign w_d[k]    = r_rp ? r_m1 : r_m0;

        // Storage, pointers and occupancy of one output FIFO.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_m0  <= '0;
                r_m1  <= '0;
                r_wp  <= 1'b0;
                r_rp  <= 1'b0;
                r_cnt <= 2'd0;
            end else begin
                if (w_push) begin
                    if (r_wp) r_m1 <= i_a_d;
                    else      r_m0 <= i_a_d;
                    r_wp <= ~r_wp;
                end
                if (w_pop) r_rp <= ~r_rp;
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 2'd1;
                    2'b01:   r_cnt <= r_cnt - 2'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    assign o_z0_v = w_v[0];
    assign o_z1_v = w_v[1];
    assign o_z2_v = w_v[2];
    assign o_z0_d = w_d[0];
    assign o_z1_d = w_d[1];
    assign o_z2_d = w_d[2];

    // A live pair carrying select 3 is a protocol error upstream.
    a_sel_legal: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_go && i_s_d == 2'd3))
        else $fatal(1, "cory_demux3: illegal select value 3 with live pair");

endmodule

// File: tb/tb_cory_demux3.sv
// tb_cory_demux3: directed scenarios plus randomized traffic checked
// against per-output queue model of the demultiplexer.
module tb_cory_demux3;

    logic       clk;
    logic       reset_n;
    logic       a_v;
    logic [7:0] a_d;
    logic       s_v;
    logic [1:0] sel;
    logic [2:0] zr;
    logic       a_r;
    logic       s_r;
    logic [2:0] zv;
    logic [7:0] zd [3];

    logic [7:0] q [3][$];
    int errors = 0;
    int checks = 0;

    cory_demux3 #(.N(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(a_v), .i_a_d(a_d), .o_a_r(a_r),
        .i_s_v(s_v), .i_s_d(sel), .o_s_r(s_r),
        .o_z0_v(zv[0]), .o_z0_d(zd[0]), .i_z0_r(zr[0]),
        .o_z1_v(zv[1]), .o_z1_d(zd[1]), .i_z1_r(zr[1]),
        .o_z2_v(zv[2]), .o_z2_d(zd[2]), .i_z2_r(zr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic av, input logic sv,
                         input logic [1:0] s, input logic [7:0] d);
        a_v = av; s_v = sv; sel = s; a_d = d;
    endtask

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        bit acc;
        acc = a_v && s_v && sel != 2'd3 && q[sel].size() < 2;
        for (int k = 0; k < 3; k++)
            if (zr[k] && q[k].size() != 0) void'(q[k].pop_front());
        if (acc) q[sel].push_back(a_d);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0);
        zr = 3'b111;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        zr = 3'b000;
        drive(1, 1, 0, 8'h00);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (zv[k] !== 1'b0 || zd[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_z%0d: v=%b d=%h want v=0 d=00", k, zv[k], zd[k]);
            end
        end
        checks++;
        if (a_r !== 1'b1 || s_r !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: a_r=%b s_r=%b want 1 1", a_r, s_r);
        end
        drive(0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        zr = 3'b000;
        drive(1, 1, 2'd1, 8'h5A);
        #1;
        checks++;
        if (a_r !== 1'b1 || s_r !== 1'b1 || zv[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: a_r=%b s_r=%b z1v=%b want 1 1 0", a_r, s_r, zv[1]);
        end
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (zv !== 3'b010 || zd[1] !== 8'h5A) begin
            errors++;
            $display("FAIL single_out: zv=%b z1d=%h want 010 5a", zv, zd[1]);
        end
        drain();
    endtask

    task automatic test_full();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
        zr = 3'b000;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'd0, exp_d[i]);
            #1;
            checks++;
            if (a_r !== (i < 2) || s_r !== (i < 2)) begin
                errors++;
                $display("FAIL full_ready%0d: a_r=%b s_r=%b want %b", i, a_r, s_r, i < 2);
            end
            if (i < 2) tick();
        end
        zr[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive(0, 0, 0, 0);
            #1;
            checks++;
            if (zv[0] !== 1'b1 || zd[0] !== exp_d[i]) begin
                errors++;
                $display("FAIL full_order%0d: v=%b d=%h want 1 %h", i, zv[0], zd[0], exp_d[i]);
            end
            tick();
        end
        checks++;
        if (zv[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: z0v=%b want 0", zv[0]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        zr = 3'b100;
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 2'd2, 8'(i));
            #1;
            checks++;
            if (a_r !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: a_r=%b want 1", i, a_r);
            end
            if (i > 0) begin
                checks++;
                if (zv[2] !== 1'b1 || zd[2] !== 8'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_out%0d: v=%b d=%h want 1 %h", i, zv[2], zd[2], 8'(i - 1));
                end
            end
            tick();
        end
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (zv[2] !== 1'b1 || zd[2] !== 8'd99) begin
            errors++;
            $display("FAIL b2b_last: v=%b d=%h want 1 63", zv[2], zd[2]);
        end
        drain();
    endtask

    task automatic test_no_block();
        zr = 3'b000;
        drive(1, 1, 2'd0, 8'h11); tick();
        drive(1, 1, 2'd0, 8'h22); tick();
        drive(1, 1, 2'd1, 8'hAA);
        #1;
        checks++;
        if (a_r !== 1'b1 || s_r !== 1'b1) begin
            errors++;
            $display("FAIL noblock_ready: a_r=%b s_r=%b want 1 1", a_r, s_r);
        end
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (zv[1] !== 1'b1 || zd[1] !== 8'hAA || zv[0] !== 1'b1) begin
            errors++;
            $display("FAIL noblock_out: z1v=%b z1d=%h z0v=%b want 1 aa 1", zv[1], zd[1], zv[0]);
        end
        drain();
    endtask

    task automatic test_partial();
        zr = 3'b000;
        drive(1, 0, 2'd0, 8'h33);
        #1;
        checks++;
        if (a_r !== 1'b0) begin
            errors++;
            $display("FAIL partial_a: a_r=%b want 0", a_r);
        end
        tick();
        drive(0, 1, 2'd0, 8'h44);
        #1;
        checks++;
        if (s_r !== 1'b0) begin
            errors++;
            $display("FAIL partial_s: s_r=%b want 0", s_r);
        end
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (zv !== 3'b000) begin
            errors++;
            $display("FAIL partial_nopush: zv=%b want 000", zv);
        end
    endtask

    task automatic test_illegal();
        drive(1, 1, 2'd3, 8'h77);
        #1;
        checks++;
        if (a_r !== 1'b1 || s_r !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ready: a_r=%b s_r=%b want 1 1", a_r, s_r);
        end
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if (zv !== 3'b000) begin
            errors++;
            $display("FAIL illegal_nopush: zv=%b want 000", zv);
        end
    endtask

    task automatic test_async_reset();
        zr = 3'b000;
        drive(1, 1, 2'd0, 8'hC1); tick();
        drive(1, 1, 2'd0, 8'hC2); tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (zv[0] !== 1'b1 || zd[0] !== 8'hC1) begin
            errors++;
            $display("FAIL areset_pre: v=%b d=%h want 1 c1", zv[0], zd[0]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (zv[0] !== 1'b0 || zd[0] !== 8'h00) begin
            errors++;
            $display("FAIL areset_now: v=%b d=%h want 0 00", zv[0], zd[0]);
        end
        for (int k = 0; k < 3; k++) q[k].delete();
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit exp_full;
        for (int n = 0; n < 2000; n++) begin
            drive(1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)),
                  8'($urandom));
            zr = 3'($urandom);
            #1;
            exp_full = q[sel].size() >= 2;
            checks++;
            if (a_r !== (s_v && !exp_full) || s_r !== (a_v && !exp_full)) begin
                errors++;
                $display("FAIL rand_ready@%0d: a_r=%b s_r=%b want %b %b", n, a_r, s_r,
                         s_v && !exp_full, a_v && !exp_full);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (zv[k] !== (q[k].size() != 0)) begin
                    errors++;
                    $display("FAIL rand_v%0d@%0d: got %b want %b", k, n, zv[k], q[k].size() != 0);
                end else if (q[k].size() != 0 && zd[k] !== q[k][0]) begin
                    errors++;
                    $display("FAIL rand_d%0d@%0d: got %h want %h", k, n, zd[k], q[k][0]);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        reset_n = 1'b0;
        zr = 3'b000;
        drive(0, 0, 0, 0);
        #1;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_no_block();
        test_partial();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cory_demux3.md
CORY_DEMUX3 -- requirements
Module: cory_demux3

Interface
REQ-001 Parameter N, default 8: data width in bits of the input and of every output stream.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port i_a_v  input  1  input data stream valid.
REQ-005 Port i_a_d  input  N  input data payload.
REQ-006 Port o_a_r  output  1  input data stream ready.
REQ-007 Port i_s_v  input  1  select stream valid.
REQ-008 Port i_s_d  input  2  select value; 0, 1, 2 address outputs z0, z1, z2; 3 is illegal.
REQ-009 Port o_s_r  output  1  select stream ready.
REQ-010 Ports o_z0_v, o_z1_v, o_z2_v  output  1 each  output stream valid.
REQ-011 Ports o_z0_d, o_z1_d, o_z2_d  output  N each  output stream payload.
REQ-012 Ports i_z0_r, i_z1_r, i_z2_r  input  1 each  output stream ready.

Function
REQ-013 The block SHALL contain one 2-entry FIFO per output k (k = 0, 1, 2), with a write pointer, a read pointer and an occupancy count (0..2).
REQ-014 Let sel = i_s_d and go = i_a_v & i_s_v; the input pair (a, s) SHALL always be consumed jointly, never one without the other.
REQ-015 For sel in 0..2: o_a_r = i_s_v & !full[sel] and o_s_r = i_a_v & !full[sel], where full[k] is the registered count[k] == 2.
REQ-016 Neither ready output SHALL depend combinationally on any i_zk_r.
REQ-017 Push to FIFO k SHALL occur when go & sel == k & !full[k]; i_a_d is written at the write pointer, which then advances modulo 2.
REQ-018 o_zk_v SHALL equal count[k] != 0, and o_zk_d SHALL equal the entry at the read pointer of FIFO k.
REQ-019 Pop from FIFO k SHALL occur when o_zk_v & i_zk_r; the read pointer then advances modulo 2.
REQ-020 Latency from input acceptance to o_zk_v SHALL be exactly 1 cycle; there is no combinational bypass.
REQ-021 A simultaneous push and pop on the same FIFO SHALL leave count unchanged; push only gives +1, pop only gives -1.
REQ-022 A push while full SHALL be impossible, because ready is low; a pop while empty SHALL be impossible, because valid is low.
REQ-023 Each output SHALL sustain 1 transfer per cycle in steady state with ready held high (count alternates between 1 and 1 via push+pop).
REQ-024 Entries SHALL leave each output in the order they were accepted; there is no ordering requirement between different outputs.
REQ-025 For sel == 3 with go high, o_a_r and o_s_r SHALL both be 1 and the pair SHALL be discarded, with no FIFO change.
REQ-026 For sel == 3, simulation builds SHALL print an error and terminate.
REQ-027 A stalled output k SHALL NOT block traffic whose sel selects another output.

Reset
REQ-028 While reset_n = 0: all counts and pointers SHALL be 0, all FIFO storage SHALL be 0, o_zk_v = 0 and o_zk_d = 0.
REQ-029 Assertion of reset_n mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-030 After reset, o_a_r and o_s_r SHALL follow REQ-015 with every FIFO empty.

Verification
REQ-031 Reset, then i_a_v = i_s_v = 1, sel = 1, d = 0x5A for one cycle with i_z1_r = 0 -> o_a_r = o_s_r = 1 that cycle; o_z1_v = 1 with d = 0x5A next cycle; o_z0_v = o_z2_v = 0.
REQ-032 sel = 0 with d = 0x01, 0x02, 0x03 on consecutive cycles, i_z0_r = 0 -> the first two are accepted; o_a_r = 0 for the third; releasing i_z0_r yields 0x01, 0x02, 0x03 in order.
REQ-033 Hold i_z2_r = 1 and drive sel = 2 with d = 0..99 back-to-back -> 100 accepted in 100 cycles and 100 emitted in order with no gap.
REQ-034 Fill z0 (i_z0_r = 0), then present sel = 1, d = 0xAA -> pair accepted immediately and o_z1_v = 1 with d = 0xAA next cycle.
REQ-035 i_a_v = 1, i_s_v = 0 -> o_a_r = 0 and no push; i_s_v = 1, i_a_v = 0 -> o_s_r = 0 and no push.
REQ-036 Assert reset_n = 0 asynchronously with z0 holding 2 entries -> o_z0_v = 0 and o_z0_d = 0 before the next clk edge.
